// File: rtl/mdu_div_ctrl_if.sv
// ----------------------------------------------------------------------------
// mdu_div_ctrl_if
// Request/response bundle between the execute stage and mdu_div_ctrl.
//   req_valid/req_ready   request handshake (execute -> controller)
//   req_funct3            100 DIV, 101 DIVU, 110 REM, 111 REMU
//   req_a/req_b/req_rd    dividend, divisor, destination tag
//   rsp_valid/rsp_ready   response handshake (controller -> execute)
//   rsp_data/rsp_rd       final result and echoed tag
//   busy                  stall indication, high whenever not idle
// master = execute stage, slave = mdu_div_ctrl.
// ----------------------------------------------------------------------------
interface mdu_div_ctrl_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_a;
   logic [XLEN-1:0] req_b;
   logic [4:0]      req_rd;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_data;
   logic [4:0]      rsp_rd;
   logic            busy;

   modport master (
      output req_valid, req_funct3, req_a, req_b, req_rd, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_rd, busy
   );

   modport slave (
      input  req_valid, req_funct3, req_a, req_b, req_rd, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_rd, busy
   );
endinterface

// File: rtl/mdu_div_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_div_ctrl
// Sequencer and sign-correction stage in front of an iterative unsigned
// divider. Converts signed operands to magnitudes, resolves divide-by-zero
// and signed overflow without using the divider, otherwise launches the
// divider, waits for completion, sign-corrects and returns the result.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   bus           request/response bundle (slave side)
//   div_start     one-cycle launch pulse to the divider
//   div_a/div_b   unsigned operand magnitudes, held through FIX
//   div_q/div_r   divider quotient / remainder
//   div_ok        divider idle / result ready (low while iterating)
// ----------------------------------------------------------------------------
module mdu_div_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   mdu_div_ctrl_if.slave   bus,
   output logic            div_start,
   output logic [XLEN-1:0] div_a,
   output logic [XLEN-1:0] div_b,
   input  logic [XLEN-1:0] div_q,
   input  logic [XLEN-1:0] div_r,
   input  logic            div_ok
);

   localparam logic [XLEN-1:0] ONE     = XLEN'(1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONE = '1;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      FIX,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic            is_rem, neg_a, neg_b, seen_busy;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] rsp_data_q;

   // Accept-cycle decode, all taken straight from the request bus.
   logic            accept, in_signed, in_rem, in_neg_a, in_neg_b;
   logic            b_zero, ovf, special;
   logic [XLEN-1:0] mag_a, mag_b, special_val, fix_val;

   assign accept    = (state == IDLE) && bus.req_valid && bus.req_funct3[2];
   assign in_signed = ~bus.req_funct3[0];
   assign in_rem    = bus.req_funct3[1];
   assign in_neg_a  = in_signed & bus.req_a[XLEN-1];
   assign in_neg_b  = in_signed & bus.req_b[XLEN-1];
   assign mag_a     = in_neg_a ? (~bus.req_a + ONE) : bus.req_a;
   assign mag_b     = in_neg_b ? (~bus.req_b + ONE) : bus.req_b;
   assign b_zero    = (bus.req_b == '0);
   assign ovf       = in_signed && (bus.req_a == MIN_INT) && (bus.req_b == ALL_ONE);
   assign special   = b_zero | ovf;

   // Divide by zero: q = all ones, r = a. Overflow: q = MIN_INT, r = 0.
   always_comb begin
      if (b_zero) special_val = in_rem ? bus.req_a : ALL_ONE;
      else        special_val = in_rem ? '0 : MIN_INT;
   end

   // Quotient sign follows neg_a ^ neg_b, remainder sign follows the dividend.
   always_comb begin
      if (is_rem) fix_val = neg_a ? (~div_r + ONE) : div_r;
      else        fix_val = (neg_a ^ neg_b) ? (~div_q + ONE) : div_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.busy      = 1'b1;
      div_start     = 1'b0;
      unique case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            bus.busy      = 1'b0;
            if (accept) state_nxt = special ? RESP : LAUNCH;
         end
         LAUNCH: begin
            div_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // Only a div_ok that follows an observed busy phase ends the wait.
            if (seen_busy && div_ok) state_nxt = FIX;
         end
         FIX: state_nxt = RESP;
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: datapath registers are reset too, because rsp_data, rsp_rd and the
   // divider operands must read zero immediately after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_rem     <= 1'b0;
         neg_a      <= 1'b0;
         neg_b      <= 1'b0;
         seen_busy  <= 1'b0;
         rd_q       <= '0;
         div_a      <= '0;
         div_b      <= '0;
         rsp_data_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  is_rem <= in_rem;
                  neg_a  <= in_neg_a;
                  neg_b  <= in_neg_b;
                  rd_q   <= bus.req_rd;
                  div_a  <= mag_a;
                  div_b  <= mag_b;
                  if (special) rsp_data_q <= special_val;
               end
            end
            LAUNCH: seen_busy <= 1'b0;
            WAIT:   if (!div_ok) seen_busy <= 1'b1;
            FIX:    rsp_data_q <= fix_val;
            default: ;
         endcase
      end
   end

   assign bus.rsp_data = rsp_data_q;
   assign bus.rsp_rd   = rd_q;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
module tb_mdu_div_ctrl;

   logic        clk;
   logic        rst;
   logic        div_start;
   logic [31:0] div_a, div_b, div_q, div_r;
   logic        div_ok;

   mdu_div_ctrl_if #(.XLEN(32)) bus ();

   mdu_div_ctrl #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .div_start (div_start),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_q     (div_q),
      .div_r     (div_r),
      .div_ok    (div_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- iterative divider model -------------------------------
   // Drops div_ok model_lazy cycles after start (0 = immediately), iterates
   // 32 cycles, then presents q/r and raises div_ok.
   int          model_lazy;
   int          pend, cnt;
   logic [31:0] la, lb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_ok <= 1'b1;
         div_q  <= '0;
         div_r  <= '0;
         pend   <= 0;
         cnt    <= 0;
         la     <= '0;
         lb     <= '0;
      end else if (div_start) begin
         la <= div_a;
         lb <= div_b;
         if (model_lazy == 0) begin
            div_ok <= 1'b0;
            cnt    <= 32;
         end else begin
            pend <= model_lazy;
         end
      end else if (pend != 0) begin
         pend <= pend - 1;
         if (pend == 1) begin
            div_ok <= 1'b0;
            cnt    <= 32;
         end
      end else if (!div_ok) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            div_ok <= 1'b1;
            div_q  <= (lb == 0) ? 32'hFFFF_FFFF : la / lb;
            div_r  <= (lb == 0) ? la : la % lb;
         end
      end
   end

   // ---------------- checking infrastructure --------------------------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      bit          special;
      int          hold;
      int          lazy;
   } vec_t;

   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

   function automatic logic [31:0] mag(input logic [2:0] f3, input logic [31:0] x);
      return (!f3[0] && x[31]) ? (32'd0 - x) : x;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int   guard, lat, starts, e, exp_lat;
      bit   seen0;
      exp_t ex;
      model_lazy = v.lazy;
      guard = 0;
      while (!bus.req_ready && guard < 100) begin
         step();
         guard++;
      end
      bus.req_funct3 = v.f3;
      bus.req_a      = v.a;
      bus.req_b      = v.b;
      bus.req_rd     = v.rd;
      bus.req_valid  = 1'b1;
      sb.push_back('{data: v.exp, rd: v.rd});
      step();
      // Scramble the request bus; the DUT must have latched everything already.
      bus.req_valid  = 1'b0;
      bus.req_funct3 = 3'($urandom);
      bus.req_a      = $urandom;
      bus.req_b      = $urandom;
      bus.req_rd     = 5'($urandom);
      lat = 1; starts = 0; e = 0; seen0 = 0;
      while (lat < 200) begin
         if (div_start) begin
            starts++;
            check({tag, "_div_a"}, div_a, mag(v.f3, v.a));
            check({tag, "_div_b"}, div_b, mag(v.f3, v.b));
         end
         if (!div_ok) seen0 = 1;
         else if (seen0 && e == 0) e = lat;
         if (bus.rsp_valid) break;
         step();
         lat++;
      end
      if (!bus.rsp_valid) begin
         check({tag, "_rsp_timeout"}, 32'(bus.rsp_valid), 32'd1);
         void'(sb.pop_front());
         return;
      end
      exp_lat = v.special ? 1 : e + 2;
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_starts"}, 32'(starts), v.special ? 32'd0 : 32'd1);
      for (int i = 0; i < v.hold; i++) begin
         step();
         check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
         check({tag, "_hold_data"}, bus.rsp_data, sb[0].data);
         check({tag, "_hold_rd"}, 32'(bus.rsp_rd), 32'(sb[0].rd));
         check({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      ex = sb.pop_front();
      check({tag, "_rsp_data"}, bus.rsp_data, ex.data);
      check({tag, "_rsp_rd"}, 32'(bus.rsp_rd), 32'(ex.rd));
      step();
      bus.rsp_ready = 1'b0;
      check({tag, "_post_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_post_req_ready"}, 32'(bus.req_ready), 32'd1);
   endtask

   vec_t vecs[15];

   initial begin
      //           f3      a             b             rd     exp          sp hold lazy
      vecs[0]  = '{F_DIVU, 32'd100,      32'd7,        5'd5,  32'd14,      0, 0, 0};
      vecs[1]  = '{F_DIV,  -32'sd7,      32'd2,        5'd1,  32'hFFFFFFFD,0, 0, 0};
      vecs[2]  = '{F_REM,  -32'sd7,      32'd2,        5'd2,  32'hFFFFFFFF,0, 0, 3};
      vecs[3]  = '{F_REM,  32'd7,        -32'sd2,      5'd3,  32'd1,       0, 0, 0};
      vecs[4]  = '{F_DIV,  32'd7,        -32'sd2,      5'd4,  32'hFFFFFFFD,0, 5, 0};
      vecs[5]  = '{F_DIV,  32'd5,        32'd0,        5'd6,  32'hFFFFFFFF,1, 0, 0};
      vecs[6]  = '{F_REMU, 32'd5,        32'd0,        5'd7,  32'd5,       1, 0, 0};
      vecs[7]  = '{F_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h80000000,1, 0, 0};
      vecs[8]  = '{F_REM,  32'h80000000, 32'hFFFFFFFF, 5'd9,  32'd0,       1, 5, 0};
      vecs[9]  = '{F_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'd0,       0, 0, 2};
      vecs[10] = '{F_REMU, 32'hFFFFFFFF, 32'h10,       5'd11, 32'hF,       0, 0, 0};
      vecs[11] = '{F_DIV,  -32'sd100,    -32'sd7,      5'd12, 32'd14,      0, 0, 0};
      vecs[12] = '{F_REM,  -32'sd100,    -32'sd7,      5'd13, 32'hFFFFFFFE,0, 0, 1};
      vecs[13] = '{F_DIV,  -32'sd5,      32'd0,        5'd14, 32'hFFFFFFFF,1, 0, 0};
      vecs[14] = '{F_REM,  -32'sd5,      32'd0,        5'd31, 32'hFFFFFFFB,1, 0, 0};

      model_lazy     = 0;
      bus.req_valid  = 1'b0;
      bus.req_funct3 = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_rd     = '0;
      bus.rsp_ready  = 1'b0;
      rst            = 1'b0;
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      check("rst_div_start", 32'(div_start), 32'd0);
      repeat (2) step();
      rst = 1'b1;
      step();

      // Non-M funct3 while idle must be ignored.
      bus.req_funct3 = 3'b000;
      bus.req_a      = 32'd50;
      bus.req_b      = 32'd5;
      bus.req_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("ign_req_ready", 32'(bus.req_ready), 32'd1);
         check("ign_busy", 32'(bus.busy), 32'd0);
         check("ign_div_start", 32'(div_start), 32'd0);
      end
      bus.req_valid = 1'b0;

      for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset asserted while waiting on the divider.
      model_lazy     = 0;
      bus.req_funct3 = F_DIVU;
      bus.req_a      = 32'hFFFF0000;
      bus.req_b      = 32'd3;
      bus.req_rd     = 5'd9;
      bus.req_valid  = 1'b1;
      step();
      bus.req_valid  = 1'b0;
      repeat (6) step();
      check("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_rsp_data", bus.rsp_data, 32'd0);
      check("mid_rst_rsp_rd", 32'(bus.rsp_rd), 32'd0);
      check("mid_rst_div_start", 32'(div_start), 32'd0);
      check("mid_rst_div_a", div_a, 32'd0);
      check("mid_rst_div_b", div_b, 32'd0);
      repeat (2) step();
      rst = 1'b1;
      step();
      run_vec('{F_DIVU, 32'd9, 32'd3, 5'd17, 32'd3, 0, 0, 0}, "post_rst");

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu_div_ctrl.md
# mdu_div_ctrl

Sequencing and sign-correction stage that sits directly upstream of the iterative unsigned divider in the M-extension coprocessor. It accepts DIV/DIVU/REM/REMU requests from the execute stage and converts signed operands to magnitudes. It resolves the RISC-V divide-by-zero and overflow cases without launching the divider, and otherwise runs a start/ok handshake with the divider. It then sign-corrects the result and returns it through a valid/ready response port tagged with the destination register.

## Interface
- XLEN, 32, operand and result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  in  XLEN  dividend (rs1).
- req_b  in  XLEN  divisor (rs2).
- req_rd  in  5  destination register tag.
- div_start  out  1  one-cycle launch pulse to the unsigned divider.
- div_a  out  XLEN  unsigned dividend magnitude.
- div_b  out  XLEN  unsigned divisor magnitude.
- div_q  in  XLEN  divider quotient.
- div_r  in  XLEN  divider remainder.
- div_ok  in  1  divider idle/result ready; low while iterating.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  XLEN  final signed/unsigned quotient or remainder.
- rsp_rd  out  5  tag echoed from the request.
- busy  out  1  pipeline stall; high whenever state is not IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT, FIX, RESP.
- Accept: in IDLE, when req_valid=1 and req_funct3[2]=1.
  - Latch the op, signed = ~funct3[0], is_rem = funct3[1], and rd.
  - Latch neg_a = signed & a[31] and neg_b = signed & b[31].
  - Latch magnitudes |a| and |b| as two's-complement negation when the corresponding neg flag is set.
  - Requests with funct3[2]=0 are ignored: no accept and no state change.
- Special cases, resolved in the accept cycle and going IDLE -> RESP with no divider activity:
  - b==0: quotient = 0xFFFFFFFF, remainder = a, for both signed and unsigned ops.
  - signed & a==0x80000000 & b==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- LAUNCH: div_start=1 for exactly this cycle, then go to WAIT. div_a and div_b hold the magnitudes from LAUNCH until FIX completes.
- WAIT:
  - seen_busy flag is cleared on entry and set when div_ok=0 is sampled.
  - Leave for FIX on the first cycle with seen_busy=1 and div_ok=1.
  - A div_ok that stays high right after launch must not end WAIT.
- FIX (exactly one cycle):
  - Quotient result: div_q, negated when neg_a^neg_b.
  - Remainder result: div_r, negated when neg_a.
  - Register the selected value into rsp_data, then go to RESP.
- RESP:
  - rsp_valid=1 with rsp_data and rsp_rd held stable until rsp_ready=1.
  - On that handshake cycle, go to IDLE; rsp_valid drops the next cycle.
- All arithmetic is modulo 2^32, and negation is ~x+1.
- Reset, at any time and in any state: state = IDLE, seen_busy = 0. The divider shares the same rst.
- Reset values of outputs:
  - 0: div_start, div_a, div_b, rsp_valid, rsp_data, rsp_rd, busy.
  - 1: req_ready.

## Timing
- Accept at cycle T. Normal path:
  - LAUNCH at T+1, with div_start high in T+1.
  - WAIT from T+2.
  - The divider drops div_ok after sampling start, iterates 32 cycles, then raises div_ok at cycle E.
  - FIX at E+1; rsp_valid first high at E+2.
  - Total for the 32-cycle divider: rsp_valid at T+37 ±1, checked against the divider model, not hard-coded.
- Special case: rsp_valid high at T+1.
- Back-to-back requests: req_ready returns the cycle after the rsp handshake, giving a minimum one-cycle bubble.
- req_* inputs are sampled only in the accept cycle; later changes are ignored.
- div_start is never high outside LAUNCH and never high in two consecutive cycles.

## Test plan
- DIVU 100/7 -> div_start pulses once, div_a=100, div_b=7; rsp_data=14, rsp_rd echoes the tag.
- Signed operands, each as a separate request:
  - DIV -7/2 -> rsp_data=0xFFFFFFFD.
  - REM -7/2 -> rsp_data=0xFFFFFFFF.
  - REM 7/-2 -> rsp_data=1.
  - DIV 7/-2 -> rsp_data=0xFFFFFFFD.
- Divide by zero:
  - DIV 5/0 -> rsp_data=0xFFFFFFFF; REMU 5/0 -> rsp_data=5.
  - rsp_valid is high the cycle after accept, and div_start never pulses.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> rsp_data=0x80000000; REM with the same operands -> rsp_data=0; no divider launch.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles in RESP -> rsp_data, rsp_rd and rsp_valid stay stable, and req_ready=0 throughout.
  - A funct3=000 request presented while IDLE is ignored.
- Reset mid-operation: assert rst during WAIT -> all outputs take their reset values immediately. A subsequent DIVU 9/3 returns 3.
